// File: rtl/rng_pkg.sv
// Shared definitions for the RNG sample path: sizing helper, default geometry,
// and the full-policy encodings also used by the RNG core.
// Contents: clog2(), DEFAULT_WIDTH, DEFAULT_DEPTH, full_policy_e.
package rng_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // What the sample buffer does with a write that arrives while it is full.
  typedef enum logic {
    FULL_DROP      = 1'b0,  // keep stored samples, discard the incoming one
    FULL_OVERWRITE = 1'b1   // discard the oldest stored sample, keep the newest
  } full_policy_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rng_fifo_mem.sv
// Purpose: DEPTH x WIDTH sample storage, one write port, one registered read port.
// Latency: read data appears one cycle after re_i; writes land at the clock edge.
// Backpressure: none; the caller owns all flow control. Read-during-write to the
//   same address returns the old contents.
// Ports: clk_i/rst_i, write (we_i, waddr_i, wdata_i), read (re_i, raddr_i) -> rdata_o.
module rng_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array is not reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Output register resets to zero and holds its value when no read occurs.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/rng_sample_fifo.sv
// Purpose: sample buffer between the RNG core and its consumers, with occupancy/status reporting.
// Latency: data_o/rd_valid_o one cycle after an accepted read; status flags one cycle after the causing edge.
// Backpressure: none upstream; writes into a full buffer are dropped or overwrite the oldest (OVERWRITE) and are counted.
// Ports: clk_i, rst_i (sync, active high); wr_en_i/data_i write side; rd_en_i -> data_o/rd_valid_o read side;
//   full_o, empty_o, almost_full_o, count_o occupancy; overflow_o/underflow_o sticky errors; drop_cnt_o lost samples.
module rng_sample_fifo
  import rng_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = 12,
  parameter int OVERWRITE = 0,
  parameter int CNT_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic [clog2(DEPTH):0] count_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic [CNT_W-1:0]      drop_cnt_o
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam full_policy_e POLICY = (OVERWRITE != 0) ? FULL_OVERWRITE : FULL_DROP;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] count;
  logic             rd_acc, wr_acc, full_hit, ow_hit;

  // Flags come straight from the registered count.
  assign full_o        = (count == OCC_W'(DEPTH));
  assign empty_o       = (count == '0);
  assign almost_full_o = (count >= OCC_W'(AF_THRESH));
  assign count_o       = count;

  // A read on an empty buffer is rejected even if a write lands the same cycle.
  assign rd_acc   = rd_en_i & ~empty_o;
  // A same-cycle read frees a slot, so a full buffer can still take the write.
  assign wr_acc   = wr_en_i & (~full_o | rd_acc);
  assign full_hit = wr_en_i & full_o & ~rd_acc;
  // Overwrite: store the sample and advance both pointers, losing the oldest.
  assign ow_hit   = full_hit & (POLICY == FULL_OVERWRITE);

  rng_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_acc | ow_hit),
    .waddr_i (wr_ptr),
    .wdata_i (data_i),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr),
    .rdata_o (data_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_valid_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      drop_cnt_o  <= '0;
    end else begin
      rd_valid_o <= rd_acc;
      if (wr_acc | ow_hit) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc | ow_hit) rd_ptr <= rd_ptr + PTR_W'(1);
      // Overwrite moves both pointers, so occupancy stays at DEPTH.
      if (wr_acc & ~rd_acc)      count <= count + OCC_W'(1);
      else if (rd_acc & ~wr_acc) count <= count - OCC_W'(1);
      if (rd_en_i & empty_o) underflow_o <= 1'b1;
      if (full_hit) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rng_sample_fifo.sv
module tb_rng_sample_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;

  // d_* : drop-newest instance, 4-bit drop counter
  logic [7:0]  d_data;
  logic        d_vld, d_full, d_empty, d_af, d_ovf, d_udf;
  logic [2:0]  d_cnt;
  logic [3:0]  d_drop;
  // o_* : overwrite-oldest instance, 16-bit drop counter
  logic [7:0]  o_data;
  logic        o_vld, o_full, o_empty, o_af, o_ovf, o_udf;
  logic [2:0]  o_cnt;
  logic [15:0] o_drop;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rng_sample_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .OVERWRITE(0), .CNT_W(4)) dut_drop (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .data_i(din), .rd_en_i(rd_en),
    .data_o(d_data), .rd_valid_o(d_vld), .full_o(d_full), .empty_o(d_empty),
    .almost_full_o(d_af), .count_o(d_cnt), .overflow_o(d_ovf), .underflow_o(d_udf),
    .drop_cnt_o(d_drop)
  );

  rng_sample_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .OVERWRITE(1), .CNT_W(16)) dut_ow (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .data_i(din), .rd_en_i(rd_en),
    .data_o(o_data), .rd_valid_o(o_vld), .full_o(o_full), .empty_o(o_empty),
    .almost_full_o(o_af), .count_o(o_cnt), .overflow_o(o_ovf), .underflow_o(o_udf),
    .drop_cnt_o(o_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; din = d; rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp_d, input logic [7:0] exp_o);
    cyc(1'b0, 8'h00, 1'b1);
    chk({tag, "_d_vld"}, d_vld, 1);
    chk({tag, "_d_data"}, d_data, exp_d);
    chk({tag, "_o_vld"}, o_vld, 1);
    chk({tag, "_o_data"}, o_data, exp_o);
  endtask

  task automatic fill4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] e);
    cyc(1'b1, a, 1'b0);
    cyc(1'b1, b, 1'b0);
    cyc(1'b1, c, 1'b0);
    cyc(1'b1, e, 1'b0);
  endtask

  initial begin
    wr_en = 1'b0; rd_en = 1'b0; din = 8'h00; rst = 1'b1;

    // 1: reset held two cycles while a write is requested
    cyc(1'b1, 8'h11, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 8'h22, 1'b0);
    chk("rst_d_cnt", d_cnt, 0);   chk("rst_o_cnt", o_cnt, 0);
    chk("rst_d_empty", d_empty, 1); chk("rst_d_full", d_full, 0);
    chk("rst_d_af", d_af, 0);     chk("rst_d_vld", d_vld, 0);
    chk("rst_d_data", d_data, 0); chk("rst_d_ovf", d_ovf, 0);
    chk("rst_d_udf", d_udf, 0);   chk("rst_d_drop", d_drop, 0);
    chk("rst_o_drop", o_drop, 0); chk("rst_o_empty", o_empty, 1);
    rst = 1'b0;

    // 2: fill with AA,FF,01,02, watch occupancy flags, then drain
    cyc(1'b1, 8'hAA, 1'b0);
    chk("w1_cnt", d_cnt, 1); chk("w1_empty", d_empty, 0); chk("w1_af", d_af, 0);
    cyc(1'b1, 8'hFF, 1'b0);
    chk("w2_cnt", d_cnt, 2); chk("w2_af", d_af, 0);
    cyc(1'b1, 8'h01, 1'b0);
    chk("w3_cnt", d_cnt, 3); chk("w3_af", d_af, 1); chk("w3_full", d_full, 0);
    cyc(1'b1, 8'h02, 1'b0);
    chk("w4_cnt", d_cnt, 4); chk("w4_full", d_full, 1); chk("w4_o_full", o_full, 1);
    rd_chk("r1", 8'hAA, 8'hAA);
    chk("r1_cnt", d_cnt, 3); chk("r1_full", d_full, 0); chk("r1_af", d_af, 1);
    rd_chk("r2", 8'hFF, 8'hFF);
    chk("r2_af", d_af, 0);
    rd_chk("r3", 8'h01, 8'h01);
    rd_chk("r4", 8'h02, 8'h02);
    chk("r4_empty", d_empty, 1); chk("r4_cnt", d_cnt, 0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle_vld", d_vld, 0); chk("idle_hold", d_data, 8'h02);

    // 3/4: write into a full buffer under both policies
    fill4(8'hAA, 8'hFF, 8'h01, 8'h02);
    cyc(1'b1, 8'h55, 1'b0);
    chk("ovf_d_cnt", d_cnt, 4);   chk("ovf_o_cnt", o_cnt, 4);
    chk("ovf_d_drop", d_drop, 1); chk("ovf_o_drop", o_drop, 1);
    chk("ovf_d_flag", d_ovf, 1);  chk("ovf_o_flag", o_ovf, 1);
    chk("ovf_o_vld", o_vld, 0);
    rd_chk("ovr1", 8'hAA, 8'hFF);
    rd_chk("ovr2", 8'hFF, 8'h01);
    rd_chk("ovr3", 8'h01, 8'h02);
    rd_chk("ovr4", 8'h02, 8'h55);
    chk("ovr_d_empty", d_empty, 1); chk("ovr_o_empty", o_empty, 1);

    // 5: simultaneous read+write while full
    fill4(8'hAA, 8'hFF, 8'h01, 8'h02);
    cyc(1'b1, 8'h77, 1'b1);
    chk("rw_d_vld", d_vld, 1);    chk("rw_d_data", d_data, 8'hAA);
    chk("rw_o_data", o_data, 8'hAA);
    chk("rw_d_cnt", d_cnt, 4);    chk("rw_o_cnt", o_cnt, 4);
    chk("rw_d_drop", d_drop, 1);  chk("rw_o_drop", o_drop, 1);
    rd_chk("rwr1", 8'hFF, 8'hFF);
    rd_chk("rwr2", 8'h01, 8'h01);
    rd_chk("rwr3", 8'h02, 8'h02);
    rd_chk("rwr4", 8'h77, 8'h77);

    // 6a: read on empty, then write+read on empty (read rejected, write kept)
    cyc(1'b0, 8'h00, 1'b1);
    chk("udf_vld", d_vld, 0); chk("udf_flag", d_udf, 1); chk("udf_o_flag", o_udf, 1);
    cyc(1'b1, 8'h33, 1'b1);
    chk("we_vld", d_vld, 0); chk("we_cnt", d_cnt, 1);
    rd_chk("we_rd", 8'h33, 8'h33);

    // 6b: 40 write/read pairs walk the pointers through ten wraps
    for (int i = 0; i < 40; i++) begin
      logic [7:0] v;
      v = 8'(i * 7 + 3);
      cyc(1'b1, v, 1'b0);
      rd_chk("wrap", v, v);
    end
    chk("wrap_empty", d_empty, 1);

    // 6c: 20 writes into a full buffer; 4-bit counter saturates
    fill4(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'hD0 + i), 1'b0);
    chk("sat_d_drop", d_drop, 4'hF);
    chk("sat_o_drop", o_drop, 16'd21);
    chk("sat_d_cnt", d_cnt, 4);
    rd_chk("sat1", 8'hC0, 8'hE0);
    rd_chk("sat2", 8'hC1, 8'hE1);
    rd_chk("sat3", 8'hC2, 8'hE2);
    rd_chk("sat4", 8'hC3, 8'hE3);

    // Reset wins over a pending read and clears sticky state
    cyc(1'b1, 8'h44, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    chk("rst2_vld", d_vld, 0);   chk("rst2_cnt", d_cnt, 0);
    chk("rst2_ovf", d_ovf, 0);   chk("rst2_udf", d_udf, 0);
    chk("rst2_drop", d_drop, 0); chk("rst2_o_drop", o_drop, 0);
    chk("rst2_data", d_data, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
